// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch stage.
//   EXC_MISALIGNED_FETCH : exception code for a fetch from a pc with pc[1:0] != 0
//   PC_STEP              : sequential pc increment
//   fetch_slot_t         : one in-flight fetch entry {valid, pc, exc}
package fetch_pkg;

  localparam logic [7:0]  EXC_MISALIGNED_FETCH = 8'h82;
  localparam logic [7:0]  EXC_NONE             = 8'h00;
  localparam logic [31:0] PC_STEP              = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [7:0]  exc;
  } fetch_slot_t;

  localparam fetch_slot_t SLOT_EMPTY = '{valid: 1'b0, pc: 32'h0, exc: EXC_NONE};

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control inputs and decode/memory-facing outputs of the
// fetch stage, bundled into one port.
//   halt, stall, flush, flush_tgt : pipeline control into fetch
//   mem_addr_0                    : word-aligned instruction memory address
//   pc_out, bubble_out, exc_out   : metadata aligned with mem_out_0, to decode
//   perf_fetched, perf_bubbles    : performance counters (only with FETCH_PERF_EN)
// master = the fetch stage, slave = the surrounding pipeline / memory.
interface fetch_stage_if;

  logic        halt;
  logic        stall;
  logic        flush;
  logic [31:0] flush_tgt;
  logic [31:0] mem_addr_0;
  logic [31:0] pc_out;
  logic        bubble_out;
  logic [7:0]  exc_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  modport master (
    input  halt, stall, flush, flush_tgt,
    output mem_addr_0, pc_out, bubble_out, exc_out
`ifdef FETCH_PERF_EN
    , output perf_fetched, perf_bubbles
`endif
  );

  modport slave (
    output halt, stall, flush, flush_tgt,
    input  mem_addr_0, pc_out, bubble_out, exc_out
`ifdef FETCH_PERF_EN
    , input perf_fetched, perf_bubbles
`endif
  );

endinterface

// File: rtl/fetch_slot.sv
// fetch_slot: one in-flight fetch entry register.
//   clk, reset : clock, synchronous active-high reset
//   halt       : hold everything (beats kill)
//   kill       : invalidate entry and clear its exception (beats hold)
//   hold       : keep current contents
//   d / q      : next entry when loading / current entry
module fetch_slot
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        kill,
  input  logic        hold,
  input  fetch_slot_t d,
  output fetch_slot_t q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SLOT_EMPTY;
    end else if (halt) begin
      q <= q;
    end else if (kill) begin
      // pc is left as-is; only valid and exc are meaningful once killed.
      q.valid <= 1'b0;
      q.exc   <= EXC_NONE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage, upstream of decode.
// Owns the fetch pc, drives the port-0 memory address, and carries pc/valid/exc
// through two in-flight slots so they line up with mem_out_0 (2-cycle memory).
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : fetch_stage_if.master (halt, stall, flush, flush_tgt in;
//           mem_addr_0, pc_out, bubble_out, exc_out out)
// Parameters: RESET_PC (first pc after reset), MEM_LATENCY (must be 2).
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_stage_if.master bus
);

  generate
    if (MEM_LATENCY != 2) begin : g_bad_latency
      $error("fetch_stage: MEM_LATENCY=%0d unsupported, only 2", MEM_LATENCY);
    end
  endgenerate

  logic [31:0] pc;
  fetch_slot_t s1_d;
  fetch_slot_t s1_q;
  fetch_slot_t s2_q;

  // Priority: reset > halt > flush > stall > normal increment (wraps at 2^32).
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (bus.halt) begin
      pc <= pc;
    end else if (bus.flush) begin
      pc <= bus.flush_tgt;
    end else if (!bus.stall) begin
      pc <= pc + PC_STEP;
    end
  end

  // NOTE: every field is assigned unconditionally here, so no latch is inferred.
  always_comb begin
    s1_d.valid = 1'b1;
    s1_d.pc    = pc;
    s1_d.exc   = (pc[1:0] != 2'b00) ? EXC_MISALIGNED_FETCH : EXC_NONE;
  end

  // S1: address issued last cycle; S2: data on mem_out_0 this cycle.
  fetch_slot u_s1 (
    .clk   (clk),
    .reset (reset),
    .halt  (bus.halt),
    .kill  (bus.flush),
    .hold  (bus.stall),
    .d     (s1_d),
    .q     (s1_q)
  );

  fetch_slot u_s2 (
    .clk   (clk),
    .reset (reset),
    .halt  (bus.halt),
    .kill  (bus.flush),
    .hold  (bus.stall),
    .d     (s1_q),
    .q     (s2_q)
  );

  // Memory sees the word address even for a misaligned pc; the exception
  // travels with the slot instead.
  assign bus.mem_addr_0 = {pc[31:2], 2'b00};
  assign bus.pc_out     = s2_q.pc;
  assign bus.bubble_out = ~s2_q.valid;
  assign bus.exc_out    = s2_q.exc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_bubbles_q;

  // Counts what decode is presented with on each cycle the stage advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 32'h0;
      perf_bubbles_q <= 32'h0;
    end else if (!bus.halt && !bus.stall) begin
      if (s2_q.valid) perf_fetched_q <= perf_fetched_q + 32'd1;
      else            perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven bench for fetch_stage (RESET_PC=0x100).
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0100), .MEM_LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        halt;
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    logic        exp_bubble;
    logic        chk_pc;     // pc_out/exc_out only checked for valid entries
    logic [31:0] exp_pc;
    logic [7:0]  exp_exc;
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic s, input logic f, input logic [31:0] t);
    bus.halt      = h;
    bus.stall     = s;
    bus.flush     = f;
    bus.flush_tgt = t;
  endtask

  // One clock edge; outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic h, input logic s, input logic f,
                         input logic [31:0] t, input logic [31:0] a, input logic b,
                         input logic c, input logic [31:0] p, input logic [7:0] e);
    vecs[i] = '{halt: h, stall: s, flush: f, tgt: t, exp_addr: a, exp_bubble: b,
                chk_pc: c, exp_pc: p, exp_exc: e};
  endtask

  initial begin
    //           h  s  f  tgt            addr           bub chk pc_out         exc
    set_vec( 0, 0, 0, 0, 32'h0,         32'h0000_0104, 1, 0, 32'h0,         8'h00);
    set_vec( 1, 0, 0, 0, 32'h0,         32'h0000_0108, 0, 1, 32'h0000_0100, 8'h00);
    set_vec( 2, 0, 0, 0, 32'h0,         32'h0000_010C, 0, 1, 32'h0000_0104, 8'h00);
    set_vec( 3, 0, 1, 0, 32'h0,         32'h0000_010C, 0, 1, 32'h0000_0104, 8'h00);
    set_vec( 4, 0, 1, 0, 32'h0,         32'h0000_010C, 0, 1, 32'h0000_0104, 8'h00);
    set_vec( 5, 0, 1, 0, 32'h0,         32'h0000_010C, 0, 1, 32'h0000_0104, 8'h00);
    set_vec( 6, 0, 0, 0, 32'h0,         32'h0000_0110, 0, 1, 32'h0000_0108, 8'h00);
    set_vec( 7, 0, 0, 0, 32'h0,         32'h0000_0114, 0, 1, 32'h0000_010C, 8'h00);
    set_vec( 8, 0, 0, 1, 32'h0000_2000, 32'h0000_2000, 1, 0, 32'h0,         8'h00);
    set_vec( 9, 0, 0, 0, 32'h0,         32'h0000_2004, 1, 0, 32'h0,         8'h00);
    set_vec(10, 0, 0, 0, 32'h0,         32'h0000_2008, 0, 1, 32'h0000_2000, 8'h00);
    set_vec(11, 0, 0, 0, 32'h0,         32'h0000_200C, 0, 1, 32'h0000_2004, 8'h00);
    set_vec(12, 0, 1, 1, 32'h0000_3000, 32'h0000_3000, 1, 0, 32'h0,         8'h00);
    set_vec(13, 0, 0, 0, 32'h0,         32'h0000_3004, 1, 0, 32'h0,         8'h00);
    set_vec(14, 0, 0, 0, 32'h0,         32'h0000_3008, 0, 1, 32'h0000_3000, 8'h00);
    set_vec(15, 0, 0, 1, 32'h0000_2002, 32'h0000_2000, 1, 0, 32'h0,         8'h00);
    set_vec(16, 0, 0, 0, 32'h0,         32'h0000_2004, 1, 0, 32'h0,         8'h00);
    set_vec(17, 0, 0, 0, 32'h0,         32'h0000_2008, 0, 1, 32'h0000_2002, 8'h82);
    set_vec(18, 1, 0, 1, 32'h0000_5000, 32'h0000_2008, 0, 1, 32'h0000_2002, 8'h82);
    set_vec(19, 1, 1, 0, 32'h0,         32'h0000_2008, 0, 1, 32'h0000_2002, 8'h82);
    set_vec(20, 0, 0, 0, 32'h0,         32'h0000_200C, 0, 1, 32'h0000_2006, 8'h82);
    set_vec(21, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 32'h0,         8'h00);
    set_vec(22, 0, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 32'h0,         8'h00);
    set_vec(23, 0, 0, 0, 32'h0,         32'h0000_0004, 0, 1, 32'hFFFF_FFFC, 8'h00);
    set_vec(24, 0, 0, 0, 32'h0,         32'h0000_0008, 0, 1, 32'h0000_0000, 8'h00);

    // Reset state.
    drive(0, 0, 0, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    check("rst_addr",   bus.mem_addr_0, 32'h0000_0100);
    check("rst_bubble", {31'h0, bus.bubble_out}, 32'h1);
    check("rst_pc",     bus.pc_out, 32'h0);
    check("rst_exc",    {24'h0, bus.exc_out}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].halt, vecs[i].stall, vecs[i].flush, vecs[i].tgt);
      tick();
      check($sformatf("v%0d_addr", i), bus.mem_addr_0, vecs[i].exp_addr);
      check($sformatf("v%0d_bubble", i), {31'h0, bus.bubble_out}, {31'h0, vecs[i].exp_bubble});
      if (vecs[i].chk_pc) begin
        check($sformatf("v%0d_pc", i), bus.pc_out, vecs[i].exp_pc);
        check($sformatf("v%0d_exc", i), {24'h0, bus.exc_out}, {24'h0, vecs[i].exp_exc});
      end
    end

    // Reset asserted mid-stall: no residual valid slot afterwards.
    drive(0, 1, 0, 32'h0);
    reset = 1'b1;
    tick();
    check("rst_stall_addr",   bus.mem_addr_0, 32'h0000_0100);
    check("rst_stall_bubble", {31'h0, bus.bubble_out}, 32'h1);
    check("rst_stall_exc",    {24'h0, bus.exc_out}, 32'h0);
    reset = 1'b0;
    drive(0, 0, 0, 32'h0);
    tick();
    check("post_rst_stall_bubble", {31'h0, bus.bubble_out}, 32'h1);
    check("post_rst_stall_addr",   bus.mem_addr_0, 32'h0000_0104);

    // Reset asserted mid-flush: reset pc wins over flush target.
    drive(0, 0, 1, 32'h0000_4000);
    reset = 1'b1;
    tick();
    check("rst_flush_addr",   bus.mem_addr_0, 32'h0000_0100);
    check("rst_flush_bubble", {31'h0, bus.bubble_out}, 32'h1);
    check("rst_flush_pc",     bus.pc_out, 32'h0);
    reset = 1'b0;
    drive(0, 0, 0, 32'h0);
    tick();
    check("rf1_bubble", {31'h0, bus.bubble_out}, 32'h1);
    tick();
    check("rf2_bubble", {31'h0, bus.bubble_out}, 32'h0);
    check("rf2_pc",     bus.pc_out, 32'h0000_0100);
    check("rf2_addr",   bus.mem_addr_0, 32'h0000_0108);

    // Halt holds even while reset is low and stall/flush toggle.
    drive(1, 0, 1, 32'h0000_6000);
    tick();
    drive(1, 1, 0, 32'h0);
    tick();
    check("halt_addr", bus.mem_addr_0, 32'h0000_0108);
    check("halt_pc",   bus.pc_out, 32'h0000_0100);
    drive(0, 0, 0, 32'h0);
    tick();
    check("unhalt_pc", bus.pc_out, 32'h0000_0104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
